pcpi_issue_ctrl: RTL



---
 rtl/pcpi_issue_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl: core-side PCPI initiator. Issues one instruction at a time
// to the coprocessor bus. It waits for a responder, with a timeout window that
// restarts on every pcpi_wait cycle. It then returns the result, or an
// illegal-instruction trap, through a valid/ready handshake.
module pcpi_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ENABLE_TIMEOUT = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    input  logic [31:0] issue_insn,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,
    output logic        issue_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        done_valid,
    output logic        done_wr,
    output logic [31:0] done_rd,
    output logic        done_trap,
    input  logic        done_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        done_valid_q, done_valid_d;
    logic        done_wr_q, done_wr_d;
    logic [31:0] done_rd_q, done_rd_d;
    logic        done_trap_q, done_trap_d;

    // State and datapath registers; synchronous active-low reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pcpi_valid_q <= 1'b0;
            insn_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            done_valid_q <= 1'b0;
            done_wr_q    <= 1'b0;
            done_rd_q    <= '0;
            done_trap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pcpi_valid_q <= pcpi_valid_d;
            insn_q       <= insn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            done_valid_q <= done_valid_d;
            done_wr_q    <= done_wr_d;
            done_rd_q    <= done_rd_d;
            done_trap_q  <= done_trap_d;
        end
    end

    // Next-state logic: issue capture, prioritised REQ resolution, result hand-off.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pcpi_valid_d = pcpi_valid_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        done_valid_d = done_valid_q;
        done_wr_d    = done_wr_q;
        done_rd_d    = done_rd_q;
        done_trap_d  = done_trap_q;

        unique case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    insn_d       = issue_insn;
                    rs1_d        = issue_rs1;
                    rs2_d        = issue_rs2;
                    pcpi_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (pcpi_ready) begin
                    done_wr_d    = pcpi_wr;
                    done_rd_d    = pcpi_rd;
                    done_trap_d  = 1'b0;
                    done_valid_d = 1'b1;
                    pcpi_valid_d = 1'b0;
                    state_d      = DONE;
                end else if (pcpi_wait) begin
                    cnt_d = '0;
                end else if (ENABLE_TIMEOUT && (cnt_q == CNT_LAST)) begin
                    done_trap_d  = 1'b1;
                    done_wr_d    = 1'b0;
                    done_rd_d    = '0;
                    done_valid_d = 1'b1;
                    pcpi_valid_d = 1'b0;
                    state_d      = DONE;
                end else if (cnt_q != CNT_LAST) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    done_trap_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issue_ready = (state_q == IDLE);
    assign pcpi_valid  = pcpi_valid_q;
    assign pcpi_insn   = insn_q;
    assign pcpi_rs1    = rs1_q;
    assign pcpi_rs2    = rs2_q;
    assign done_valid  = done_valid_q;
    assign done_wr     = done_wr_q;
    assign done_rd     = done_rd_q;
    assign done_trap   = done_trap_q;

endmodule
